// File: rtl/da_sample_feeder.sv
// da_sample_feeder: sample front end for the distr_arith DA-LUT FIR core.
// Each accepted signed sample is shifted into an 8-tap delay line. The taps
// are then held for one computation frame, the core's sum is captured, and
// the sum is returned on a valid/ready output port.
module da_sample_feeder #(
  parameter int DW           = 8,
  parameter int SUM_W        = 32,
  parameter int FRAME_CYCLES = 16
) (
  input  logic             clk3,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [DW-1:0]    in_data,
  output logic             in_ready,
  input  logic             flush,
  output logic [DW-1:0]    x1_bit,
  output logic [DW-1:0]    x2_bit,
  output logic [DW-1:0]    x3_bit,
  output logic [DW-1:0]    x4_bit,
  output logic [DW-1:0]    x5_bit,
  output logic [DW-1:0]    x6_bit,
  output logic [DW-1:0]    x7_bit,
  output logic [DW-1:0]    x8_bit,
  output logic             da_start,
  input  logic [SUM_W-1:0] da_sum,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_data,
  input  logic             out_ready
);

  localparam int CW = $clog2(FRAME_CYCLES);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_OUT  = 2'd2;

  localparam logic [CW-1:0] LAST_CNT = CW'(FRAME_CYCLES - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          tap_clear;

  // Flush outranks a pending sample: a flushing IDLE cycle never consumes data.
  assign in_ready  = (state == S_IDLE) && !flush;
  assign accept    = in_ready && in_valid;
  assign tap_clear = (state == S_IDLE) && flush;

  // Frame sequencer: start pulse, frame counter, result capture and handshake.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      da_start  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every read in this block
      // sees the value from before the edge; cnt==LAST_CNT below compares the
      // old count, which is what places the capture on edge E0+FRAME_CYCLES.
      da_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            da_start <= 1'b1;
            cnt      <= '0;
            state    <= S_RUN;
          end
        end
        S_RUN: begin
          cnt <= cnt + CW'(1);
          if (cnt == LAST_CNT) begin
            out_data  <= da_sum;
            out_valid <= 1'b1;
            state     <= S_OUT;
          end
        end
        S_OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tap delay line: changes only on an accept or flush edge, so the core sees
  // stable operands for the whole frame.
  always_ff @(posedge clk3 or negedge reset) begin
    if (!reset) begin
      // NOTE: the delay line is a handful of registers, not a RAM, and the core
      // must see zero history after reset, so it is reset explicitly.
      x1_bit <= '0;
      x2_bit <= '0;
      x3_bit <= '0;
      x4_bit <= '0;
      x5_bit <= '0;
      x6_bit <= '0;
      x7_bit <= '0;
      x8_bit <= '0;
    end else if (tap_clear) begin
      x1_bit <= '0;
      x2_bit <= '0;
      x3_bit <= '0;
      x4_bit <= '0;
      x5_bit <= '0;
      x6_bit <= '0;
      x7_bit <= '0;
      x8_bit <= '0;
    end else if (accept) begin
      x1_bit <= in_data;
      x2_bit <= x1_bit;
      x3_bit <= x2_bit;
      x4_bit <= x3_bit;
      x5_bit <= x4_bit;
      x6_bit <= x5_bit;
      x7_bit <= x6_bit;
      x8_bit <= x7_bit;
    end
  end

endmodule

// File: tb/tb_da_sample_feeder.sv
// Bench for da_sample_feeder: a behavioural DA core (sum of k*xk, registered)
// drives da_sum; expected results are pushed to a scoreboard queue on each
// accepted sample and popped when out_valid rises.
module tb_da_sample_feeder;

  localparam int DW    = 8;
  localparam int SUM_W = 32;
  localparam int FRAME = 16;

  logic             clk3;
  logic             reset;
  logic             in_valid;
  logic [DW-1:0]    in_data;
  logic             in_ready;
  logic             flush;
  logic [DW-1:0]    x1_bit, x2_bit, x3_bit, x4_bit, x5_bit, x6_bit, x7_bit, x8_bit;
  logic             da_start;
  logic [SUM_W-1:0] da_sum;
  logic             out_valid;
  logic [SUM_W-1:0] out_data;
  logic             out_ready;

  int n_cmp = 0;
  int n_bad = 0;

  int hist [8];
  int exp_q [$];

  logic [DW-1:0] taps_obs [8];

  da_sample_feeder #(.DW(DW), .SUM_W(SUM_W), .FRAME_CYCLES(FRAME)) dut (
    .clk3      (clk3),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .flush     (flush),
    .x1_bit    (x1_bit),
    .x2_bit    (x2_bit),
    .x3_bit    (x3_bit),
    .x4_bit    (x4_bit),
    .x5_bit    (x5_bit),
    .x6_bit    (x6_bit),
    .x7_bit    (x7_bit),
    .x8_bit    (x8_bit),
    .da_start  (da_start),
    .da_sum    (da_sum),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready)
  );

  assign taps_obs[0] = x1_bit;
  assign taps_obs[1] = x2_bit;
  assign taps_obs[2] = x3_bit;
  assign taps_obs[3] = x4_bit;
  assign taps_obs[4] = x5_bit;
  assign taps_obs[5] = x6_bit;
  assign taps_obs[6] = x7_bit;
  assign taps_obs[7] = x8_bit;

  initial clk3 = 1'b0;
  always #5 clk3 = ~clk3;

  // Behavioural DA core: registered weighted sum of the taps it is given.
  function automatic int core_sum();
    int acc = 0;
    for (int k = 0; k < 8; k++) acc += (k + 1) * int'($signed(taps_obs[k]));
    return acc;
  endfunction

  always @(posedge clk3) da_sum <= SUM_W'(core_sum());

  task automatic model_clear();
    for (int k = 0; k < 8; k++) hist[k] = 0;
    exp_q.delete();
  endtask

  task automatic note_accepted(input int s);
    int e = 0;
    for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = s;
    for (int k = 0; k < 8; k++) e += (k + 1) * hist[k];
    exp_q.push_back(e);
  endtask

  // Offer one sample once in_ready is seen; returns one edge after the accept.
  task automatic accept(input int s);
    int n = 0;
    while (!in_ready && n < 60) begin
      @(posedge clk3); #1;
      n++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_wait: in_ready=%b required 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    in_data  = DW'(s);
    @(posedge clk3); #1;
    in_valid = 1'b0;
    note_accepted(s);
    n_cmp++;
    if (da_start !== 1'b1) begin
      n_bad++;
      $display("FAIL accept_start: da_start=%b required 1", da_start);
    end
    n_cmp++;
    if (x1_bit !== DW'(s)) begin
      n_bad++;
      $display("FAIL accept_x1: x1_bit=%h required %h", x1_bit, DW'(s));
    end
  endtask

  // Count edges from the accept to out_valid and score the captured result.
  task automatic await_result();
    int n = 0;
    int e;
    do begin
      @(posedge clk3); #1;
      n++;
      if (n == 1) begin
        n_cmp++;
        if (da_start !== 1'b0 || in_ready !== 1'b0) begin
          n_bad++;
          $display("FAIL run_entry: da_start=%b in_ready=%b required 0 0", da_start, in_ready);
        end
      end
    end while (out_valid !== 1'b1 && n < 40);
    n_cmp++;
    if (n != FRAME || out_valid !== 1'b1) begin
      n_bad++;
      $display("FAIL latency: out_valid=%b after %0d edges required 1 after %0d", out_valid, n, FRAME);
      return;
    end
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_bad++;
      $display("FAIL scoreboard: result %0d with empty queue", $signed(out_data));
    end else begin
      e = exp_q.pop_front();
      if (out_data !== SUM_W'(e)) begin
        n_bad++;
        $display("FAIL out_data: got %0d required %0d", $signed(out_data), e);
      end
    end
  endtask

  // With out_ready high, the handshake edge follows the result edge.
  task automatic finish_handshake();
    @(posedge clk3); #1;
    n_cmp++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL handshake: out_valid=%b in_ready=%b required 0 1", out_valid, in_ready);
    end
  endtask

  task automatic run_frame(input int s);
    accept(s);
    await_result();
    finish_handshake();
  endtask

  task automatic expect_reset_state(input string tag);
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (taps_obs[k] !== '0) begin
        n_bad++;
        $display("FAIL %s_tap%0d: got %h required 00", tag, k + 1, taps_obs[k]);
      end
    end
    n_cmp++;
    if (da_start !== 1'b0 || out_valid !== 1'b0 || out_data !== '0 || in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL %s_ctrl: da_start=%b out_valid=%b out_data=%h in_ready=%b required 0 0 0 1",
               tag, da_start, out_valid, out_data, in_ready);
    end
  endtask

  task automatic test_reset();
    accept(4);
    repeat (3) begin @(posedge clk3); #1; end
    reset = 1'b0;
    #1;
    expect_reset_state("reset");
    @(posedge clk3); #1;
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_impulse();
    int stim [9] = '{1, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 9; i++) run_frame(stim[i]);
  endtask

  task automatic test_sign_extremes();
    run_frame(-128);
    accept(127);
    n_cmp++;
    if (x2_bit !== 8'h80) begin
      n_bad++;
      $display("FAIL sign_x2: x2_bit=%h required 80", x2_bit);
    end
    await_result();
    finish_handshake();
  endtask

  task automatic test_backpressure();
    logic [SUM_W-1:0] held;
    out_ready = 1'b0;
    accept(2);
    await_result();
    held     = out_data;
    in_valid = 1'b1;
    in_data  = 8'd9;
    repeat (5) begin
      @(posedge clk3); #1;
      n_cmp++;
      if (out_valid !== 1'b1 || out_data !== held || in_ready !== 1'b0 || x1_bit !== 8'd2) begin
        n_bad++;
        $display("FAIL backpressure: out_valid=%b out_data=%h in_ready=%b x1=%h required 1 %h 0 02",
                 out_valid, out_data, in_ready, x1_bit, held);
      end
    end
    out_ready = 1'b1;
    finish_handshake();
    @(posedge clk3); #1;
    in_valid = 1'b0;
    note_accepted(9);
    n_cmp++;
    if (da_start !== 1'b1 || x1_bit !== 8'd9 || x2_bit !== 8'd2) begin
      n_bad++;
      $display("FAIL bp_accept: da_start=%b x1=%h x2=%h required 1 09 02", da_start, x1_bit, x2_bit);
    end
    await_result();
    finish_handshake();
  endtask

  task automatic test_flush();
    for (int i = 0; i < 8; i++) run_frame(5);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd3;
    #1;
    n_cmp++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_ready: in_ready=%b required 0", in_ready);
    end
    @(posedge clk3); #1;
    for (int k = 0; k < 8; k++) begin
      n_cmp++;
      if (taps_obs[k] !== '0) begin
        n_bad++;
        $display("FAIL flush_tap%0d: got %h required 00", k + 1, taps_obs[k]);
      end
    end
    n_cmp++;
    if (da_start !== 1'b0) begin
      n_bad++;
      $display("FAIL flush_consumed: da_start=%b required 0", da_start);
    end
    flush    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    accept(3);
    for (int k = 1; k < 8; k++) begin
      n_cmp++;
      if (taps_obs[k] !== '0) begin
        n_bad++;
        $display("FAIL post_flush_tap%0d: got %h required 00", k + 1, taps_obs[k]);
      end
    end
    await_result();
    finish_handshake();
  endtask

  task automatic test_reset_mid_run();
    bit seen = 1'b0;
    accept(6);
    repeat (7) begin @(posedge clk3); #1; end
    reset = 1'b0;
    #1;
    expect_reset_state("mid_run_reset");
    @(posedge clk3); #1;
    reset = 1'b1;
    model_clear();
    repeat (40) begin
      @(posedge clk3); #1;
      if (out_valid !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (seen) begin
      n_bad++;
      $display("FAIL aborted_frame: out_valid seen=%b required 0", seen);
    end
    test_impulse();
  endtask

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    model_clear();
    repeat (3) @(posedge clk3);
    #1;
    reset = 1'b1;
    test_reset();
    test_impulse();
    test_sign_extremes();
    test_backpressure();
    test_flush();
    test_reset_mid_run();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/da_sample_feeder.md
# da_sample_feeder

Front-end producer for the `distr_arith` DA-LUT FIR core. It accepts one signed 8-bit sample per valid/ready handshake and shifts it into an 8-tap delay line. It then presents the taps to the core as `x1_bit`..`x8_bit`, holds them stable for one 16-cycle computation frame, captures `sum`, and returns it on a valid/ready output port. It is the block that drives the core's inputs and consumes its result, sitting between the sample source and `distr_arith`.

## Interface
- `DW`, 8: sample width, signed two's complement.
- `SUM_W`, 32: DA result width, signed.
- `FRAME_CYCLES`, 16: `clk3` edges the core needs from `da_start` to a valid `sum`; minimum 2.
- `clk3`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  sample offered.
- `in_data`  in  DW  signed sample.
- `in_ready`  out  1  sample accepted on an edge where `in_valid && in_ready`.
- `flush`  in  1  synchronous tap clear; honored only in IDLE.
- `x1_bit`..`x8_bit`  out  DW each  tap registers to the core; `x1_bit` is the newest sample.
- `da_start`  out  1  one-cycle pulse marking the start of a frame.
- `da_sum`  in  SUM_W  core result (`sum`).
- `out_valid`  out  1  result available.
- `out_data`  out  SUM_W  captured result, signed.
- `out_ready`  in  1  result consumed on an edge where `out_valid && out_ready`.

## Operation
- FSM states: IDLE, RUN, OUT. The state and a counter `cnt` (width clog2(FRAME_CYCLES)) are registered.
- `in_ready = (state==IDLE) && !flush`. This is combinational and is high in every other case only while in IDLE.
- IDLE, accept edge:
  - Taps shift: `x1_bit<=in_data`, and `xk_bit<=x(k-1)_bit` for k=2..8. The old `x8_bit` is discarded.
  - `da_start<=1`, `cnt<=0`, state goes to RUN.
- IDLE with `flush=1`: all taps go to 0 and no sample is consumed, even if `in_valid=1`. Flush wins.
- RUN:
  - `da_start<=0` and `cnt<=cnt+1` on each edge.
  - On the edge where `cnt==FRAME_CYCLES-1`: `out_data<=da_sum`, `out_valid<=1`, state goes to OUT.
- OUT:
  - `out_valid` stays high and `out_data` stays stable until `out_ready`.
  - On the handshake edge: `out_valid<=0`, state goes to IDLE.
  - `flush` and `in_valid` are ignored.
- Taps never change outside the accept and flush edges, so `x*_bit` is stable for the entire frame.
- Arithmetic: no computation. Samples and the result pass through bit-exact with sign preserved. There is no saturation or truncation.
- Reset (`reset=0`, asynchronous):
  - state=IDLE, `cnt=0`, taps=0, `da_start=0`, `out_valid=0`, `out_data=0`.
  - `in_ready` follows `!flush`.
  - Reset mid-RUN or mid-OUT aborts the frame. No `out_valid` follows after release.

## Timing
- Let E0 be the accept edge. After E0, taps are updated and `da_start=1` for exactly one cycle (E0→E1).
- `da_sum` is sampled at E0+FRAME_CYCLES (E16 by default). `out_valid` is high from E16.
- With `out_ready` held high, the handshake is at E17, IDLE is reached after E17, and the next accept can be at E18.
- Throughput is one sample per FRAME_CYCLES+2 edges.
- Backpressure: OUT is held indefinitely and `in_ready=0` throughout.

## Test plan
The bench models the core as `da_sum = Σ k·xk_bit` (k=1..8), registered, valid any time within the frame.

1. **Reset:** assert `reset=0` mid-stream, then release.
   - Required: all taps 0, `da_start=0`, `out_valid=0`, `out_data=0`, `in_ready=1`.
2. **Impulse:** feed samples 1,0,0,0,0,0,0,0,0 with `out_ready=1`.
   - Required outputs: 1,2,3,4,5,6,7,8,0.
   - Each `da_start` is exactly one cycle, and `out_valid` rises exactly 16 edges after it.
3. **Sign extremes:** feed -128, then 127.
   - Required: `x1_bit`=0x80 and output -128; then `x1_bit`=127, `x2_bit`=-128 and output -129.
4. **Backpressure:** hold `out_ready=0` for 5 cycles in OUT while `in_valid=1`, `in_data=9`.
   - Required: `out_data` stable, `in_ready=0`, and 9 is not accepted.
   - 9 is accepted on the first edge in IDLE after the result handshake.
5. **Flush:** load 8 samples of 5, then in IDLE drive `flush=1` with `in_valid=1`, `in_data=3`.
   - Required: taps all 0 and sample not consumed.
   - Next accept of 3: `x1_bit=3`, others 0, output 3.
6. **Reset mid-RUN:** assert reset at `cnt=7`, then release.
   - Required: reset values immediately, no `out_valid` for 40 cycles, and the next frame behaves as in scenario 2.
